// File: rtl/dla_acl_fanin_pipeline_if.sv
// Bus bundle for dla_acl_fanin_pipeline: per-copy inputs in, reduced out, primed flag.
// sticky_clear/out_sticky exist only when DLA_FANIN_STICKY_EN is defined.
interface dla_acl_fanin_pipeline_if #(
   parameter int NUM_INPUTS = 4,
   parameter int WIDTH      = 1
);
   logic [NUM_INPUTS-1:0][WIDTH-1:0] in;
   logic [WIDTH-1:0]                 out;
   logic                             primed;
`ifdef DLA_FANIN_STICKY_EN
   logic                             sticky_clear;
   logic [WIDTH-1:0]                 out_sticky;

   modport master (output in, output sticky_clear, input out, input primed, input out_sticky);
   modport slave  (input in, input sticky_clear, output out, output primed, output out_sticky);
`else
   modport master (output in, input out, input primed);
   modport slave  (input in, output out, output primed);
`endif
endinterface

// File: rtl/dla_acl_fanin_pipeline.sv
// Pipelined fan-in reduction tree (OR/AND) with primed flag.
// Optional sticky accumulator enabled by macro DLA_FANIN_STICKY_EN.
module dla_acl_fanin_pipeline #(
   parameter int NUM_INPUTS   = 4,
   parameter int WIDTH        = 1,
   parameter int GROUP_SIZE   = 4,
   parameter int REDUCE_OP    = 0,
   parameter int EXTRA_STAGES = 0
) (
   input logic                      clk,
   input logic                      resetn,
   dla_acl_fanin_pipeline_if.slave  bus
);
   function automatic int tree_depth(input int n, input int g);
      int d;
      int span;
      d    = 0;
      span = 1;
      while (span < n) begin
         span = span * g;
         d++;
      end
      return d;
   endfunction

   function automatic int level_nodes(input int n, input int g, input int k);
      int m;
      m = n;
      for (int i = 0; i < k; i++) m = (m + g - 1) / g;
      return m;
   endfunction

   localparam int               DEPTH = tree_depth(NUM_INPUTS, GROUP_SIZE);
   localparam int               LAT   = DEPTH + EXTRA_STAGES;
   localparam logic [WIDTH-1:0] IDENT = (REDUCE_OP != 0) ? '1 : '0;

   logic [WIDTH-1:0] root;
   logic [WIDTH-1:0] result;
   logic             primed;

   // Level 0 is the raw input bus; every later level is a registered row of nodes.
   for (genvar k = 0; k <= DEPTH; k++) begin : g_lvl
      localparam int NK = level_nodes(NUM_INPUTS, GROUP_SIZE, k);
      logic [NK-1:0][WIDTH-1:0] v;

      if (k == 0) begin : g_src
         assign v = bus.in;
      end else begin : g_node
         localparam int NP = level_nodes(NUM_INPUTS, GROUP_SIZE, k - 1);
         logic [NK*GROUP_SIZE-1:0][WIDTH-1:0]   pad;
         logic [NK-1:0][WIDTH-1:0]              lvl_d;
         (* dont_merge *) logic [NK-1:0][WIDTH-1:0] lvl_q;

         // Unused slots of a short last group hold the identity so they never mask a result.
         always_comb begin
            pad   = {(NK*GROUP_SIZE){IDENT}};
            lvl_d = '0;
            for (int i = 0; i < NP; i++) pad[i] = g_lvl[k-1].v[i];
            for (int n = 0; n < NK; n++) begin
               lvl_d[n] = IDENT;
               for (int j = 0; j < GROUP_SIZE; j++) begin
                  lvl_d[n] = (REDUCE_OP != 0) ? (lvl_d[n] & pad[n*GROUP_SIZE+j])
                                              : (lvl_d[n] | pad[n*GROUP_SIZE+j]);
               end
            end
         end

         always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) lvl_q <= '0;
            else         lvl_q <= lvl_d;
         end

         assign v = lvl_q;
      end
   end

   assign root = g_lvl[DEPTH].v[0];

   if (EXTRA_STAGES == 0) begin : g_no_extra
      assign result = root;
   end else begin : g_extra
      logic [EXTRA_STAGES-1:0][WIDTH-1:0]                ext_d;
      (* dont_merge *) logic [EXTRA_STAGES-1:0][WIDTH-1:0] ext_q;

      always_comb begin
         ext_d    = '0;
         ext_d[0] = root;
         for (int i = 1; i < EXTRA_STAGES; i++) ext_d[i] = ext_q[i-1];
      end

      always_ff @(posedge clk or negedge resetn) begin
         if (!resetn) ext_q <= '0;
         else         ext_q <= ext_d;
      end

      assign result = ext_q[EXTRA_STAGES-1];
   end

   // A purely combinational pipe is trustworthy at all times, including during reset.
   if (LAT == 0) begin : g_prime_tied
      assign primed = 1'b1;
   end else begin : g_prime_cnt
      localparam int            CW    = $clog2(LAT + 1);
      localparam logic [CW-1:0] LAT_C = CW'(LAT);
      logic [CW-1:0] cnt_d;
      logic [CW-1:0] cnt_q;

      always_comb begin
         cnt_d = cnt_q;
         if (cnt_q != LAT_C) cnt_d = cnt_q + CW'(1);
      end

      always_ff @(posedge clk or negedge resetn) begin
         if (!resetn) cnt_q <= '0;
         else         cnt_q <= cnt_d;
      end

      assign primed = (cnt_q == LAT_C);
   end

   assign bus.out    = result;
   assign bus.primed = primed;

`ifdef DLA_FANIN_STICKY_EN
   logic [WIDTH-1:0] sticky_d;
   logic [WIDTH-1:0] sticky_q;

   // Clear wins over a same-cycle set; nothing accumulates until the pipe is primed.
   always_comb begin
      sticky_d = sticky_q;
      if (primed) sticky_d = (sticky_q | result) & ~{WIDTH{bus.sticky_clear}};
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) sticky_q <= '0;
      else         sticky_q <= sticky_d;
   end

   assign bus.out_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_dla_acl_fanin_pipeline.sv
// Bench for dla_acl_fanin_pipeline: several parameterisations checked against a
// flat whole-bus reduction model; sticky checks compile in with DLA_FANIN_STICKY_EN.
module tb_dla_acl_fanin_pipeline;
  localparam int NI = 8;
  // a: OR N5 G2 | b: AND N5 G2 | c: AND N3 G4 | d: N1 E0 | e: N1 E2 | f: OR N7 G3 W4 E1 | g: AND N9 G2 W3 E1 | h: OR N4 G4 W4
  localparam int N_I   [NI] = '{5, 5, 3, 1, 1, 7, 9, 4};
  localparam int W_I   [NI] = '{1, 1, 1, 1, 1, 4, 3, 4};
  localparam int LAT_I [NI] = '{3, 3, 1, 0, 2, 3, 5, 1};
  localparam bit AND_I [NI] = '{0, 1, 1, 0, 0, 0, 1, 0};

  // ---------------- clock / reset ----------------
  logic clk    = 1'b0;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  dla_acl_fanin_pipeline_if #(.NUM_INPUTS(5), .WIDTH(1)) if_a ();
  dla_acl_fanin_pipeline_if #(.NUM_INPUTS(5), .WIDTH(1)) if_b ();
  dla_acl_fanin_pipeline_if #(.NUM_INPUTS(3), .WIDTH(1)) if_c ();
  dla_acl_fanin_pipeline_if #(.NUM_INPUTS(1), .WIDTH(1)) if_d ();
  dla_acl_fanin_pipeline_if #(.NUM_INPUTS(1), .WIDTH(1)) if_e ();
  dla_acl_fanin_pipeline_if #(.NUM_INPUTS(7), .WIDTH(4)) if_f ();
  dla_acl_fanin_pipeline_if #(.NUM_INPUTS(9), .WIDTH(3)) if_g ();
  dla_acl_fanin_pipeline_if #(.NUM_INPUTS(4), .WIDTH(4)) if_h ();

  dla_acl_fanin_pipeline #(.NUM_INPUTS(5), .WIDTH(1), .GROUP_SIZE(2), .REDUCE_OP(0), .EXTRA_STAGES(0))
    u_a (.clk(clk), .resetn(resetn), .bus(if_a));
  dla_acl_fanin_pipeline #(.NUM_INPUTS(5), .WIDTH(1), .GROUP_SIZE(2), .REDUCE_OP(1), .EXTRA_STAGES(0))
    u_b (.clk(clk), .resetn(resetn), .bus(if_b));
  dla_acl_fanin_pipeline #(.NUM_INPUTS(3), .WIDTH(1), .GROUP_SIZE(4), .REDUCE_OP(1), .EXTRA_STAGES(0))
    u_c (.clk(clk), .resetn(resetn), .bus(if_c));
  dla_acl_fanin_pipeline #(.NUM_INPUTS(1), .WIDTH(1), .GROUP_SIZE(4), .REDUCE_OP(0), .EXTRA_STAGES(0))
    u_d (.clk(clk), .resetn(resetn), .bus(if_d));
  dla_acl_fanin_pipeline #(.NUM_INPUTS(1), .WIDTH(1), .GROUP_SIZE(4), .REDUCE_OP(0), .EXTRA_STAGES(2))
    u_e (.clk(clk), .resetn(resetn), .bus(if_e));
  dla_acl_fanin_pipeline #(.NUM_INPUTS(7), .WIDTH(4), .GROUP_SIZE(3), .REDUCE_OP(0), .EXTRA_STAGES(1))
    u_f (.clk(clk), .resetn(resetn), .bus(if_f));
  dla_acl_fanin_pipeline #(.NUM_INPUTS(9), .WIDTH(3), .GROUP_SIZE(2), .REDUCE_OP(1), .EXTRA_STAGES(1))
    u_g (.clk(clk), .resetn(resetn), .bus(if_g));
  dla_acl_fanin_pipeline #(.NUM_INPUTS(4), .WIDTH(4), .GROUP_SIZE(4), .REDUCE_OP(0), .EXTRA_STAGES(0))
    u_h (.clk(clk), .resetn(resetn), .bus(if_h));

  logic [63:0] in_flat  [NI];
  logic [63:0] out_obs  [NI];
  logic        prim_obs [NI];

  assign in_flat[0] = 64'(if_a.in);  assign out_obs[0] = 64'(if_a.out);  assign prim_obs[0] = if_a.primed;
  assign in_flat[1] = 64'(if_b.in);  assign out_obs[1] = 64'(if_b.out);  assign prim_obs[1] = if_b.primed;
  assign in_flat[2] = 64'(if_c.in);  assign out_obs[2] = 64'(if_c.out);  assign prim_obs[2] = if_c.primed;
  assign in_flat[3] = 64'(if_d.in);  assign out_obs[3] = 64'(if_d.out);  assign prim_obs[3] = if_d.primed;
  assign in_flat[4] = 64'(if_e.in);  assign out_obs[4] = 64'(if_e.out);  assign prim_obs[4] = if_e.primed;
  assign in_flat[5] = 64'(if_f.in);  assign out_obs[5] = 64'(if_f.out);  assign prim_obs[5] = if_f.primed;
  assign in_flat[6] = 64'(if_g.in);  assign out_obs[6] = 64'(if_g.out);  assign prim_obs[6] = if_g.primed;
  assign in_flat[7] = 64'(if_h.in);  assign out_obs[7] = 64'(if_h.out);  assign prim_obs[7] = if_h.primed;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int cyc      = 0;
  int last_rel = 0;
  logic [63:0] hist      [NI][256];
  logic [63:0] out_log   [NI][64];
  logic        prim_log  [NI][64];
  logic [3:0]  exp_sticky = '0;
  logic [3:0]  sticky_log [64];

  // Whole-bus reduction: every copy folded together per bit position.
  function automatic logic [63:0] ref_reduce(input logic [63:0] flat, input int n,
                                             input int w, input bit is_and);
    logic [63:0] r;
    r = '0;
    for (int b = 0; b < w; b++) begin
      r[b] = is_and;
      for (int c = 0; c < n; c++)
        r[b] = is_and ? (r[b] & flat[c*w+b]) : (r[b] | flat[c*w+b]);
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    if_a.in = '0; if_b.in = '0; if_c.in = '0; if_d.in = '0;
    if_e.in = '0; if_f.in = '0; if_g.in = '0; if_h.in = '0;
`ifdef DLA_FANIN_STICKY_EN
    if_a.sticky_clear = 1'b0; if_b.sticky_clear = 1'b0; if_c.sticky_clear = 1'b0;
    if_d.sticky_clear = 1'b0; if_e.sticky_clear = 1'b0; if_f.sticky_clear = 1'b0;
    if_g.sticky_clear = 1'b0; if_h.sticky_clear = 1'b0;
`endif
  endtask

  task automatic drive_random();
    if_a.in = ($urandom_range(0, 3) == 0) ? 5'(1 << $urandom_range(0, 4)) : 5'd0;
    if_b.in = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'h1f;
    if_c.in = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'h7;
    if_d.in = 1'($urandom);
    if_e.in = 1'($urandom);
    if_f.in = 28'($urandom) & 28'($urandom) & 28'($urandom);
    if_g.in = ($urandom_range(0, 2) == 0) ? 27'($urandom) : 27'h7ffffff;
    if_h.in = ($urandom_range(0, 3) == 0) ? (16'($urandom) & 16'($urandom)) : 16'h0000;
`ifdef DLA_FANIN_STICKY_EN
    if_h.sticky_clear = ($urandom_range(0, 7) == 0);
`endif
  endtask

  // One cycle: inputs already driven; record, check at negedge, advance past posedge.
  task automatic run_cycle();
    int age;
    logic [63:0] exp_out;
    #1;
    age = cyc - last_rel;
    for (int i = 0; i < NI; i++) hist[i][cyc % 256] = in_flat[i];
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("primed[%0d] age %0d", i, age), 64'(prim_obs[i]), 64'(age >= LAT_I[i]));
      if (age >= LAT_I[i]) begin
        exp_out = ref_reduce(hist[i][(cyc - LAT_I[i]) % 256], N_I[i], W_I[i], AND_I[i]);
        chk($sformatf("out[%0d] age %0d", i, age), out_obs[i], exp_out);
      end
      if (age < 64) begin
        out_log[i][age]  = out_obs[i];
        prim_log[i][age] = prim_obs[i];
      end
    end
`ifdef DLA_FANIN_STICKY_EN
    chk($sformatf("out_sticky age %0d", age), 64'(if_h.out_sticky), 64'(exp_sticky));
    if (age < 64) sticky_log[age] = if_h.out_sticky;
    if (age >= LAT_I[7]) begin
      exp_out    = ref_reduce(hist[7][(cyc - LAT_I[7]) % 256], N_I[7], W_I[7], AND_I[7]);
      exp_sticky = (exp_sticky | exp_out[3:0]) & ~{4{if_h.sticky_clear}};
    end
`endif
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Called just after a posedge; asserts reset mid-cycle and releases after hold edges.
  task automatic apply_reset(input int hold);
    #2 resetn = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      if (LAT_I[i] == 0) begin
        chk($sformatf("rst primed[%0d]", i), 64'(prim_obs[i]), 64'd1);
        chk($sformatf("rst comb out[%0d]", i), out_obs[i], 64'(in_flat[i][0]));
      end else begin
        chk($sformatf("rst primed[%0d]", i), 64'(prim_obs[i]), 64'd0);
        chk($sformatf("rst out[%0d]", i), out_obs[i], 64'd0);
      end
    end
`ifdef DLA_FANIN_STICKY_EN
    chk("rst out_sticky", 64'(if_h.out_sticky), 64'd0);
`endif
    repeat (hold) @(posedge clk);
    #1;
    resetn     = 1'b1;
    last_rel   = cyc;
    exp_sticky = '0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    drive_idle();
    if_d.in = 1'b1;
    @(posedge clk);
    #1;
    apply_reset(3);

    for (int t = 0; t < 20; t++) begin
      if_a.in = (t == 10) ? 5'b10000 : 5'b00000;
      if_b.in = (t == 12) ? 5'b11011 : 5'b11111;
      if_c.in = (t >= 2)  ? 3'b111 : 3'b000;
      if_d.in = 1'(t % 2);
      if_e.in = 1'(t == 5);
      if_f.in = (t == 7) ? 28'h0100000 : 28'h0;
      if_g.in = 27'h7ffffff;
      if_h.in = (t == 3) ? 16'h0020 : ((t == 8) ? 16'h0008 : 16'h0000);
`ifdef DLA_FANIN_STICKY_EN
      if_h.sticky_clear = (t == 9);
`endif
      run_cycle();
    end

    chk("or pulse before", out_log[0][12], 64'd0);
    chk("or pulse at lat", out_log[0][13], 64'd1);
    chk("or pulse after", out_log[0][14], 64'd0);
    chk("or primed cyc2", 64'(prim_log[0][2]), 64'd0);
    chk("or primed cyc3", 64'(prim_log[0][3]), 64'd1);
    chk("and held high", out_log[1][14], 64'd1);
    chk("and dip", out_log[1][15], 64'd0);
    chk("and recover", out_log[1][16], 64'd1);
    chk("pad before", out_log[2][2], 64'd0);
    chk("pad identity", out_log[2][3], 64'd1);
    chk("extra2 before", out_log[4][6], 64'd0);
    chk("extra2 at lat", out_log[4][7], 64'd1);
    chk("extra2 primed", 64'(prim_log[4][2]), 64'd1);
`ifdef DLA_FANIN_STICKY_EN
    chk("sticky set", 64'(sticky_log[5]), 64'h2);
    chk("sticky held", 64'(sticky_log[9]), 64'h2);
    chk("sticky clear wins", 64'(sticky_log[10]), 64'h0);
`endif

    // Mid-stream reset while the OR pipe is driving a 1.
    if_a.in = 5'b00001;
`ifdef DLA_FANIN_STICKY_EN
    if_h.sticky_clear = 1'b0;
`endif
    repeat (5) run_cycle();
    chk("or high before reset", out_obs[0], 64'd1);
    apply_reset(2);
    repeat (6) run_cycle();
    chk("or primed after rerelease", 64'(prim_obs[0]), 64'd1);

    for (int r = 0; r < 2; r++) begin
      repeat (150) begin
        drive_random();
        run_cycle();
      end
      apply_reset(1);
    end
    repeat (10) begin
      drive_random();
      run_cycle();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
